seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised, double-buffered multiplexer for common-anode seven-segment displays. Drives DIGITS digits from one clock. Adds the following per-digit features:
- hex decode and decimal point;
- blanking and blinking;
- global PWM brightness;
- tear-free frame-synchronous updates.

It sits between the game/score logic and the board's anode/segment pins and replaces the fixed four-digit scanner.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- DELAY, 50000, clock cycles per digit slot (>=1)
- BLINK_DIV, 64, full scan frames per blink half-period (>=1)
- BRIGHT_W, 3, width of brightness control
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures all digit inputs into the shadow bank
- digits_in  in  4*DIGITS  hex nibbles; digit i at [4i+3:4i]
- dp_in  in  DIGITS  decimal point enable per digit, 1 = lit
- blank_in  in  DIGITS  1 = digit dark
- blink_in  in  DIGITS  1 = digit blinks
- bright  in  BRIGHT_W  duty control, unbuffered
- seg_n  out  8  active-low segments: [0]=a … [6]=g, [7]=dp
- an_n  out  DIGITS  active-low anodes, at most one low
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
**Prescaler**
- Counts 0..DELAY-1, then wraps.
- A "slot tick" occurs on the cycle the prescaler equals DELAY-1.
- Width is max(1, clog2(DELAY)).

**Digit index**
- The digit index idx advances on each slot tick.
- From DIGITS-1 it wraps to 0. That wrap tick is the frame boundary.

**Shadow bank**
- load captures digits_in, dp_in, blank_in and blink_in into the shadow bank on the next edge and sets a pending flag.
- A load while pending overwrites the shadow bank; the last load wins.

**Active bank**
- At a frame boundary with pending set, the active bank takes the shadow contents and pending clears.
- Display always reads the active bank, so no frame ever mixes old and new values.

**Blink**
- A frame counter counts 0..BLINK_DIV-1 at frame boundaries.
- On wrap, blink_phase toggles.
- A digit with active blink bit = 1 is dark while blink_phase = 1.

**Brightness**
- A free-running BRIGHT_W-bit pwm counter increments every cycle.
- The digit is lit only while pwm <= bright.
- bright = all-ones gives 100% duty. bright = 0 gives a duty of 1/2^BRIGHT_W.

**Output register** (computed each cycle from current idx, active bank, blink_phase and pwm)
- Digit lit (not blanked, not blink-dark, pwm <= bright):
  - an_n = all ones except bit idx = 0.
  - seg_n[6:0] = glyph of the nibble; seg_n[7] = ~dp.
- Digit dark: an_n = all ones, seg_n = 8'hFF.

**Glyphs** (standard hex, a–g order)
- 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
- 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E
- Values include dp off.

**frame_tick** is registered and high for the one cycle after each frame-boundary tick.

## Timing
**Reset** (next edge after rst = 1, from any state)
- prescaler, idx, frame counter, pwm and blink_phase = 0.
- pending = 0.
- active and shadow digits = 0, dp = 0, blink = 0, blank = all ones.
- seg_n = 8'hFF, an_n = all ones, frame_tick = 0.
- The display stays dark until the first load is promoted.

**Latency**
- Outputs lag idx, pwm and the active bank by exactly one cycle.
- A load in cycle t appears on the pins 1 cycle after the first frame boundary after t+1. Worst case is about DIGITS*DELAY+2 cycles.

**Simultaneous load and frame-boundary tick**
- Active takes the old shadow; the shadow takes the new inputs; pending stays 1.
- The new values appear one frame later.

**Other boundaries**
- A bright change takes effect on the pins within 2 cycles.
- With DELAY = 1 the index advances every cycle.
- idx never reaches DIGITS; the counters wrap with no glitch cycle on an_n (never two bits low).

## Test plan
Configuration for all scenarios: DIGITS=4, DELAY=4, BLINK_DIV=2, BRIGHT_W=2, bright=3 unless stated.

1. **Reset state.** Hold rst 3 cycles, then release with no load. Required: seg_n=FF and an_n=F for 40 cycles; frame_tick pulses every 16 cycles.
2. **Basic scan.** load digits_in=16'h8210, dp_in=4'b0001, blank_in=0. Required: after promotion, slots show an_n=E/seg_n=40, D/F9, B/A4, 7/80, each for 4 cycles, repeating.
3. **Double buffering.** Issue load 16'h1111 mid-frame, then load 16'h2222 two cycles later. Required: the next frame shows only 2222 (A4 on every digit); no frame ever mixes values.
4. **Load on the frame-boundary tick.** Load 16'h3333 on the boundary tick. Required: the next frame shows the previous contents, the following frame shows B0 on all digits.
5. **Blink and blank.** blink_in=4'b0010, blank_in=4'b1000. Required: digit 3 is never lit; digit 1 is lit for 2 frames, dark for 2 frames, and so on; digits 0 and 2 are always lit.
6. **Brightness.** Set bright=0. Required: within each slot an_n is low 1 cycle of every 4 (pwm=0); seg_n=FF otherwise. Then assert rst mid-slot. Required: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - digit-data and pin bundle for the seven-segment scanner
interface seg_scan_mux_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 3
);
  logic                  load;
  logic [4*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [DIGITS-1:0]     blink_in;
  logic [BRIGHT_W-1:0]   bright;
  logic [7:0]            seg_n;
  logic [DIGITS-1:0]     an_n;
  logic                  frame_tick;

  // Score/game logic side: supplies digit data, observes the pins.
  modport master (
    output load, digits_in, dp_in, blank_in, blink_in, bright,
    input  seg_n, an_n, frame_tick
  );

  // Scanner side.
  modport slave (
    input  load, digits_in, dp_in, blank_in, blink_in, bright,
    output seg_n, an_n, frame_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - double-buffered common-anode seven-segment scan multiplexer
module seg_scan_mux #(
  parameter int DIGITS    = 4,
  parameter int DELAY     = 50000,
  parameter int BLINK_DIV = 64,
  parameter int BRIGHT_W  = 3
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_mux_if.slave bus
);

  localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_DIV - 1);

  // Timebase and scan position
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                phase_q, phase_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;

  // Shadow bank (written by load) and active bank (read by the display)
  logic [4*DIGITS-1:0] sh_dig_q, sh_dig_d, act_dig_q, act_dig_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [DIGITS-1:0]   sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
  logic                pending_q, pending_d;

  // Registered pins
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                ftick_q, ftick_d;

  logic                slot_tick;
  logic                frame_wrap;
  logic                lit;
  logic [3:0]          nibble;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Next-state for counters and banks, plus the pin values for the current slot
  always_comb begin
    slot_tick  = (presc_q == PRESC_LAST);
    frame_wrap = slot_tick && (idx_q == IDX_LAST);

    presc_d = slot_tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (slot_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + 1'b1;
      end
    end

    pwm_d = pwm_q + 1'b1;

    // Promotion uses the shadow as it was before this edge, so a load that
    // coincides with the boundary stays pending for the following frame.
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_blink_d = act_blink_q;
    pending_d   = pending_q;
    if (frame_wrap && pending_q) begin
      act_dig_d   = sh_dig_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
      act_blink_d = sh_blink_q;
      pending_d   = 1'b0;
    end

    sh_dig_d   = sh_dig_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_blink_d = sh_blink_q;
    if (bus.load) begin
      sh_dig_d   = bus.digits_in;
      sh_dp_d    = bus.dp_in;
      sh_blank_d = bus.blank_in;
      sh_blink_d = bus.blink_in;
      pending_d  = 1'b1;
    end

    nibble = act_dig_q[{idx_q, 2'b00} +: 4];
    lit    = !act_blank_q[idx_q]
          && !(act_blink_q[idx_q] && phase_q)
          && (pwm_q <= bus.bright);

    seg_d = 8'hFF;
    an_d  = '1;
    if (lit) begin
      seg_d        = {~act_dp_q[idx_q], glyph(nibble)};
      an_d[idx_q]  = 1'b0;
    end
    ftick_d = frame_wrap;
  end

  // State and output registers; reset leaves the display dark until a load is promoted
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      fcnt_q      <= '0;
      phase_q     <= 1'b0;
      pwm_q       <= '0;
      sh_dig_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '1;
      sh_blink_q  <= '0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      act_blink_q <= '0;
      pending_q   <= 1'b0;
      seg_q       <= 8'hFF;
      an_q        <= '1;
      ftick_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      phase_q     <= phase_d;
      pwm_q       <= pwm_d;
      sh_dig_q    <= sh_dig_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      sh_blink_q  <= sh_blink_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      act_blink_q <= act_blink_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      ftick_q     <= ftick_d;
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.an_n       = an_q;
  assign bus.frame_tick = ftick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard bench for seg_scan_mux
module tb_seg_scan_mux;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int BD = 2;
  localparam int BW = 2;
  localparam int FR = N * D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_mux_if #(.DIGITS(N), .BRIGHT_W(BW)) bus ();

  seg_scan_mux #(.DIGITS(N), .DELAY(D), .BLINK_DIV(BD), .BRIGHT_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          m;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } load_t;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] an;
    logic       ft;
    int         n;
  } exp_t;

  load_t loads[$];
  exp_t  sb[$];
  int    n;
  int    compared   = 0;
  int    mismatched = 0;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Pins expected one cycle after the design sits at cycle n since reset.
  // The active bank holds the newest load strictly before the last frame boundary.
  function automatic exp_t model(input int cyc, input logic [1:0] br);
    exp_t       e;
    load_t      a;
    int         idx, pwm, phase, b;
    logic       lit;
    logic [3:0] onehot;
    logic [7:0] g;
    a.m = -1; a.dig = 16'h0; a.dp = 4'h0; a.blank = 4'hF; a.blink = 4'h0;
    if (cyc >= FR) begin
      b = (cyc / FR) * FR - 1;
      foreach (loads[i]) if (loads[i].m < b) a = loads[i];
    end
    idx    = (cyc / D) % N;
    pwm    = cyc % 4;
    phase  = ((cyc / FR) / BD) % 2;
    lit    = !a.blank[idx] && !(a.blink[idx] && phase == 1) && (pwm <= int'(br));
    onehot = 4'b0001 << idx;
    g      = glyph_tab[a.dig[idx*4 +: 4]];
    e.an   = lit ? ~onehot : 4'hF;
    e.seg  = lit ? {~a.dp[idx], g[6:0]} : 8'hFF;
    e.ft   = (cyc % FR) == (FR - 1);
    e.n    = cyc;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.seg = 8'hFF; e.an = 4'hF; e.ft = 1'b0; e.n = -1;
    return e;
  endfunction

  // One clock of stimulus; the expected pins for this cycle go to the scoreboard
  task automatic cycle(input logic ld, input logic [15:0] dg, input logic [3:0] dp,
                       input logic [3:0] bl, input logic [3:0] bk);
    load_t r;
    bus.load      = ld;
    bus.digits_in = dg;
    bus.dp_in     = dp;
    bus.blank_in  = bl;
    bus.blink_in  = bk;
    if (ld) begin
      r.m = n; r.dig = dg; r.dp = dp; r.blank = bl; r.blink = bk;
      loads.push_back(r);
    end
    sb.push_back(model(n, bus.bright));
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic idle_until(input int modv, input int res);
    for (int i = 0; i < 64 && (n % modv) != res; i++) idle(1);
  endtask

  // Monitor: every cycle the pins present an output, compare with the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      if (bus.seg_n !== e.seg) begin
        mismatched++;
        $display("FAIL seg_n n=%0d got=%h want=%h", e.n, bus.seg_n, e.seg);
      end
      compared++;
      if (bus.an_n !== e.an) begin
        mismatched++;
        $display("FAIL an_n n=%0d got=%h want=%h", e.n, bus.an_n, e.an);
      end
      compared++;
      if (bus.frame_tick !== e.ft) begin
        mismatched++;
        $display("FAIL frame_tick n=%0d got=%b want=%b", e.n, bus.frame_tick, e.ft);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    bus.blank_in  = '0;
    bus.blink_in  = '0;
    bus.bright    = 2'd3;
    n             = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back(reset_exp());

    // Dark after reset, frame_tick every 16 cycles
    idle(40);

    // Basic scan
    cycle(1'b1, 16'h8210, 4'b0001, 4'b0000, 4'b0000);
    idle(48);

    // Double buffering: two loads in one frame, last wins
    idle_until(FR, 5);
    cycle(1'b1, 16'h1111, 4'h0, 4'h0, 4'h0);
    idle(1);
    cycle(1'b1, 16'h2222, 4'h0, 4'h0, 4'h0);
    idle(40);

    // Load coinciding with the frame-boundary tick
    idle_until(FR, FR - 1);
    cycle(1'b1, 16'h3333, 4'h0, 4'h0, 4'h0);
    idle(40);

    // Blink and blank
    cycle(1'b1, 16'h4567, 4'b0100, 4'b1000, 4'b0010);
    idle(150);

    // Minimum brightness
    bus.bright = 2'd0;
    idle(40);
    bus.bright = 2'd2;
    idle(20);

    // Randomised loads and brightness
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 6) == 0) bus.bright = 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 19) == 0), 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Reset mid-slot
    bus.bright = 2'd3;
    idle_until(D, 2);
    rst      = 1'b1;
    bus.load = 1'b0;
    sb.push_back(reset_exp());
    @(posedge clk);
    #1;
    rst = 1'b0;
    n   = 0;
    loads.delete();
    idle(20);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
